// File: rtl/conv_param_store.sv
// Parameter memory for the 1D convolution datapath (filter length 3).
// Holds three weight banks plus one bias bank, each NUM_FILTERS deep. The banks are
// loaded and read back through a configuration port. While the frame recycler replays
// a frame once per filter, the current filter's weights and bias are streamed one cycle
// after each accepted cycle_en_i, so they line up with the registered recycler data.
module conv_param_store #(
  parameter int unsigned FRAME_LEN   = 50,
  parameter int unsigned VECTOR_LEN  = 13,
  parameter int unsigned NUM_FILTERS = 8,
  localparam int unsigned BW         = 8,
  localparam int unsigned BIAS_BW    = 32,
  localparam int unsigned VECTOR_BW  = VECTOR_LEN * BW,
  localparam int unsigned ADDR_BW    = $clog2(NUM_FILTERS),
  localparam int unsigned BANK_BW    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cycle_en_i,
  input  logic                 rd_en_i,
  input  logic                 wr_en_i,
  input  logic [BANK_BW-1:0]   rd_wr_bank_i,
  input  logic [ADDR_BW-1:0]   rd_wr_addr_i,
  input  logic [VECTOR_BW-1:0] wr_data_i,
  output logic [VECTOR_BW-1:0] rd_data_o,
  output logic [VECTOR_BW-1:0] data0_o,
  output logic [VECTOR_BW-1:0] data1_o,
  output logic [VECTOR_BW-1:0] data2_o,
  output logic [BIAS_BW-1:0]   bias_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 ready_i
);

  localparam int unsigned POS_BW = $clog2(FRAME_LEN);

  localparam logic [BANK_BW-1:0] BankTap0 = 2'd0;
  localparam logic [BANK_BW-1:0] BankTap1 = 2'd1;
  localparam logic [BANK_BW-1:0] BankTap2 = 2'd2;
  localparam logic [BANK_BW-1:0] BankBias = 2'd3;

  localparam logic [POS_BW-1:0]  PosLast    = POS_BW'(FRAME_LEN - 1);
  localparam logic [ADDR_BW-1:0] FilterLast = ADDR_BW'(NUM_FILTERS - 1);

  // Parameter banks
  logic [VECTOR_BW-1:0] w0_q   [NUM_FILTERS];
  logic [VECTOR_BW-1:0] w0_d   [NUM_FILTERS];
  logic [VECTOR_BW-1:0] w1_q   [NUM_FILTERS];
  logic [VECTOR_BW-1:0] w1_d   [NUM_FILTERS];
  logic [VECTOR_BW-1:0] w2_q   [NUM_FILTERS];
  logic [VECTOR_BW-1:0] w2_d   [NUM_FILTERS];
  logic [BIAS_BW-1:0]   bias_q [NUM_FILTERS];
  logic [BIAS_BW-1:0]   bias_d [NUM_FILTERS];

  // Configuration read path
  logic                 addr_ok;
  logic [VECTOR_BW-1:0] rd_entry;
  logic [VECTOR_BW-1:0] rd_data_q, rd_data_d;

  // Streaming path
  logic                 step;
  logic                 pos_wrap;
  logic                 filter_wrap;
  logic [POS_BW-1:0]    pos_cnt_q, pos_cnt_d;
  logic [ADDR_BW-1:0]   filter_cnt_q, filter_cnt_d;
  logic [VECTOR_BW-1:0] data0_q, data0_d;
  logic [VECTOR_BW-1:0] data1_q, data1_d;
  logic [VECTOR_BW-1:0] data2_q, data2_d;
  logic [BIAS_BW-1:0]   bias_out_q, bias_out_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;

  // Depth need not be a power of two; out-of-range config addresses are dropped.
  assign addr_ok = (32'(rd_wr_addr_i) < NUM_FILTERS);

  // Bank write: one entry per cycle, the bias bank keeps only the low word.
  always_comb begin
    w0_d   = w0_q;
    w1_d   = w1_q;
    w2_d   = w2_q;
    bias_d = bias_q;
    if (wr_en_i && addr_ok) begin
      unique case (rd_wr_bank_i)
        BankTap0: w0_d[rd_wr_addr_i]   = wr_data_i;
        BankTap1: w1_d[rd_wr_addr_i]   = wr_data_i;
        BankTap2: w2_d[rd_wr_addr_i]   = wr_data_i;
        BankBias: bias_d[rd_wr_addr_i] = wr_data_i[BIAS_BW-1:0];
        default:  ;
      endcase
    end
  end

  // Read mux sees the pre-write bank contents, so read-during-write returns old data.
  always_comb begin
    rd_entry = '0;
    if (addr_ok) begin
      unique case (rd_wr_bank_i)
        BankTap0: rd_entry = w0_q[rd_wr_addr_i];
        BankTap1: rd_entry = w1_q[rd_wr_addr_i];
        BankTap2: rd_entry = w2_q[rd_wr_addr_i];
        BankBias: rd_entry = VECTOR_BW'($signed(bias_q[rd_wr_addr_i]));
        default:  rd_entry = '0;
      endcase
    end
  end

  // Read data register holds between strobes.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = rd_entry;
    end
  end

  assign step        = cycle_en_i && ready_i;
  assign pos_wrap    = (pos_cnt_q == PosLast);
  assign filter_wrap = (filter_cnt_q == FilterLast);

  // Sequencer and output stage: advance only on an accepted step, otherwise hold.
  always_comb begin
    pos_cnt_d    = pos_cnt_q;
    filter_cnt_d = filter_cnt_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    bias_out_d   = bias_out_q;
    valid_d      = 1'b0;
    last_d       = 1'b0;
    if (step) begin
      data0_d    = w0_q[filter_cnt_q];
      data1_d    = w1_q[filter_cnt_q];
      data2_d    = w2_q[filter_cnt_q];
      bias_out_d = bias_q[filter_cnt_q];
      valid_d    = 1'b1;
      last_d     = pos_wrap && filter_wrap;
      if (pos_wrap) begin
        pos_cnt_d    = '0;
        filter_cnt_d = filter_wrap ? '0 : filter_cnt_q + ADDR_BW'(1);
      end else begin
        pos_cnt_d = pos_cnt_q + POS_BW'(1);
      end
    end
  end

  // Bank storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w0_q   <= '{default: '0};
      w1_q   <= '{default: '0};
      w2_q   <= '{default: '0};
      bias_q <= '{default: '0};
    end else begin
      w0_q   <= w0_d;
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      bias_q <= bias_d;
    end
  end

  // Read register, counters and streaming outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q    <= '0;
      pos_cnt_q    <= '0;
      filter_cnt_q <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      bias_out_q   <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      pos_cnt_q    <= pos_cnt_d;
      filter_cnt_q <= filter_cnt_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      bias_out_q   <= bias_out_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign data0_o   = data0_q;
  assign data1_o   = data1_q;
  assign data2_o   = data2_q;
  assign bias_o    = bias_out_q;
  assign valid_o   = valid_q;
  assign last_o    = last_q;

endmodule

// File: tb/tb_conv_param_store.sv
// Scoreboard bench for conv_param_store: the stimulus side keeps a reference model of
// the banks and counters and queues expected parameter sets; a negedge monitor pops and
// compares whenever valid_o is high, and checks held values otherwise.
module tb_conv_param_store;

  localparam int FL = 50;
  localparam int VL = 13;
  localparam int NF = 8;
  localparam int VW = VL * 8;
  localparam int AW = $clog2(NF);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cycle_en_i = 1'b0;
  logic          rd_en_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [1:0]    rd_wr_bank_i = '0;
  logic [AW-1:0] rd_wr_addr_i = '0;
  logic [VW-1:0] wr_data_i = '0;
  logic [VW-1:0] rd_data_o;
  logic [VW-1:0] data0_o, data1_o, data2_o;
  logic [31:0]   bias_o;
  logic          valid_o, last_o;
  logic          ready_i = 1'b1;

  conv_param_store #(
    .FRAME_LEN  (FL),
    .VECTOR_LEN (VL),
    .NUM_FILTERS(NF)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cycle_en_i  (cycle_en_i),
    .rd_en_i     (rd_en_i),
    .wr_en_i     (wr_en_i),
    .rd_wr_bank_i(rd_wr_bank_i),
    .rd_wr_addr_i(rd_wr_addr_i),
    .wr_data_i   (wr_data_i),
    .rd_data_o   (rd_data_o),
    .data0_o     (data0_o),
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .bias_o      (bias_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .ready_i     (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [VW-1:0] d0;
    logic [VW-1:0] d1;
    logic [VW-1:0] d2;
    logic [31:0]   b;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t held;

  // Reference model
  logic [VW-1:0] wm[3][NF];
  logic [31:0]   bm[NF];
  int            f, p;
  logic [VW-1:0] rd_cur;
  logic          exp_v;
  logic          mon_en = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [VW-1:0] pat(input logic [7:0] v);
    return {VL{v}};
  endfunction

  function automatic logic [VW-1:0] mread(input int b, input int a);
    if (b == 3) return {{(VW-32){bm[a][31]}}, bm[a]};
    return wm[b][a];
  endfunction

  task automatic model_clear();
    for (int a = 0; a < NF; a++) begin
      for (int b = 0; b < 3; b++) wm[b][a] = '0;
      bm[a] = '0;
    end
    f = 0;
    p = 0;
    rd_cur = '0;
    exp_v = 1'b0;
    held = '0;
    sb.delete();
  endtask

  // One clock: derive expectations from the driven inputs, then cross the edge.
  task automatic tick();
    logic [VW-1:0] rd_nxt;
    logic          v_nxt;
    exp_t          e;
    rd_nxt = rd_cur;
    v_nxt  = 1'b0;
    if (!rst_i) begin
      if (rd_en_i) rd_nxt = mread(int'(rd_wr_bank_i), int'(rd_wr_addr_i));
      if (cycle_en_i && ready_i) begin
        e.d0   = wm[0][f];
        e.d1   = wm[1][f];
        e.d2   = wm[2][f];
        e.b    = bm[f];
        e.last = (f == NF - 1) && (p == FL - 1);
        sb.push_back(e);
        v_nxt = 1'b1;
        p++;
        if (p == FL) begin
          p = 0;
          f = (f + 1) % NF;
        end
      end
      if (wr_en_i) begin
        if (rd_wr_bank_i == 2'd3) bm[rd_wr_addr_i] = wr_data_i[31:0];
        else wm[rd_wr_bank_i][rd_wr_addr_i] = wr_data_i;
      end
    end
    @(posedge clk_i);
    #1;
    rd_cur = rd_nxt;
    exp_v  = v_nxt;
  endtask

  task automatic wr(input int b, input int a, input logic [VW-1:0] d);
    wr_en_i = 1'b1;
    rd_wr_bank_i = 2'(b);
    rd_wr_addr_i = AW'(a);
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic rd(input int b, input int a);
    rd_en_i = 1'b1;
    rd_wr_bank_i = 2'(b);
    rd_wr_addr_i = AW'(a);
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic step(input logic en, input logic rdy);
    cycle_en_i = en;
    ready_i = rdy;
    tick();
  endtask

  // Asserted just after a negedge so the monitor has already consumed pending outputs.
  task automatic do_reset();
    @(negedge clk_i);
    #1;
    cycle_en_i = 1'b0;
    ready_i = 1'b1;
    rd_en_i = 1'b0;
    wr_en_i = 1'b0;
    rst_i = 1'b1;
    mon_en = 1'b1;
    model_clear();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Monitor
  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("valid_o", 128'(valid_o), 128'(exp_v));
      chk("rd_data_o", 128'(rd_data_o), 128'(rd_cur));
      if (valid_o) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got valid_o=1 required no output (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data0_o", 128'(data0_o), 128'(e.d0));
          chk("data1_o", 128'(data1_o), 128'(e.d1));
          chk("data2_o", 128'(data2_o), 128'(e.d2));
          chk("bias_o", 128'(bias_o), 128'(e.b));
          chk("last_o", 128'(last_o), 128'(e.last));
          held = e;
        end
      end else begin
        chk("hold_data0", 128'(data0_o), 128'(held.d0));
        chk("hold_data1", 128'(data1_o), 128'(held.d1));
        chk("hold_data2", 128'(data2_o), 128'(held.d2));
        chk("hold_bias", 128'(bias_o), 128'(held.b));
        chk("idle_last", 128'(last_o), 128'(1'b0));
      end
    end
  end

  initial begin
    model_clear();
    do_reset();

    // Every entry reads back 0 after reset
    for (int b = 0; b < 4; b++) for (int a = 0; a < NF; a++) rd(b, a);

    // Load: bank0 byte k+1, banks 1/2 offset so a tap swap shows, bias -5*k
    for (int a = 0; a < NF; a++) begin
      wr(0, a, pat(8'(a + 1)));
      wr(1, a, pat(8'(8'h10 + a + 1)));
      wr(2, a, pat(8'(8'h20 + a + 1)));
      wr(3, a, VW'(32'(-5 * a)));
    end
    for (int b = 0; b < 4; b++) for (int a = 0; a < NF; a++) rd(b, a);
    rd(3, 1);
    chk("bias1_sext", 128'(rd_cur), 128'({{(VW-32){1'b1}}, 32'hFFFF_FFFB}));

    // Read and write of the same entry in one cycle returns the old value
    rd_en_i = 1'b1;
    wr_en_i = 1'b1;
    rd_wr_bank_i = 2'd2;
    rd_wr_addr_i = AW'(5);
    wr_data_i = pat(8'hAA);
    tick();
    rd_en_i = 1'b0;
    wr_en_i = 1'b0;
    rd(2, 5);
    wr(2, 5, pat(8'h26));

    // Full pass plus the wrap back to filter 0
    for (int i = 0; i < NF * FL + 1; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Alternating enable
    for (int i = 0; i < 120; i++) step(1'(i % 2 == 0), 1'b1);
    step(1'b0, 1'b1);

    // Stall with enable held
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

    // Stream into filter 2, then rewrite bank1 addr 2 during a step
    for (int g = 0; g < 2 * NF * FL && !(f == 2 && p >= 5); g++) step(1'b1, 1'b1);
    cycle_en_i = 1'b1;
    ready_i = 1'b1;
    wr_en_i = 1'b1;
    rd_wr_bank_i = 2'd1;
    rd_wr_addr_i = AW'(2);
    wr_data_i = pat(8'hC3);
    tick();
    wr_en_i = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Reset mid-pass, distinguish filters 0 and 1 and check the restart point
    do_reset();
    wr(0, 0, pat(8'h5A));
    wr(0, 1, pat(8'hA5));
    wr(3, 0, VW'(32'h1234_5678));
    wr(3, 1, VW'(32'h8765_4321));
    for (int i = 0; i < FL + 2; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
